// File: rtl/sram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : sram_port_arbiter
//  Purpose  : Controller for a single-port, 1-cycle-read, lane-masked SRAM
//             macro. Zero-fills the array after reset, then shares the macro
//             between two valid/ready requesters with a round-robin arbiter.
//             Each requester owns a one-entry read-response buffer, so read
//             data is captured the cycle after the access and is never lost
//             to the macro's post-read garbage cycles.
//  Ports    : clock, reset      - clock and asynchronous active-high reset
//             init_done         - high once the zero-fill has finished
//             reqN_*            - request channel N (valid/ready, write, addr,
//                                 lane mask, write data)
//             respN_*           - read-response channel N (valid/ready, data)
//             sram_*            - RW0-style macro interface
//  Revision : 1.0  initial release
// ============================================================================
module sram_port_arbiter #(
  parameter int ADDR_W         = 12,
  parameter int DATA_W         = 64,
  parameter int MASK_W         = 4,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  output logic              init_done,
  // requester 0
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [MASK_W-1:0] req0_mask,
  input  logic [DATA_W-1:0] req0_wdata,
  // requester 1
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [MASK_W-1:0] req1_mask,
  input  logic [DATA_W-1:0] req1_wdata,
  // read responses
  output logic              resp0_valid,
  input  logic              resp0_ready,
  output logic [DATA_W-1:0] resp0_rdata,
  output logic              resp1_valid,
  input  logic              resp1_ready,
  output logic [DATA_W-1:0] resp1_rdata,
  // SRAM macro
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [MASK_W-1:0] sram_wmask,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_fill;
  logic              r_last_req1;   // 1 = requester 1 won the most recent grant
  logic [1:0]        r_rd_infl;     // read issued to the macro last cycle
  logic [1:0]        r_resp_valid;
  logic [DATA_W-1:0] r_resp_rdata0;
  logic [DATA_W-1:0] r_resp_rdata1;

  logic [1:0]        w_valid;
  logic [1:0]        w_write;
  logic [1:0]        w_resp_rdy;
  logic [1:0]        w_rd_ok;
  logic [1:0]        w_elig;
  logic [1:0]        w_gnt;

  assign w_valid    = {req1_valid,  req0_valid};
  assign w_write    = {req1_write,  req0_write};
  assign w_resp_rdy = {resp1_ready, resp0_ready};

  // A read may only go out when its response slot will be free by the time
  // the data is captured: nothing in flight and the buffer empty or popping.
  assign w_rd_ok = ~r_rd_infl & (~r_resp_valid | w_resp_rdy);
  assign w_elig  = w_valid & (w_write | w_rd_ok);

  always_comb begin
    w_state_nxt = r_state;
    w_gnt       = 2'b00;
    sram_en     = 1'b0;
    sram_wmode  = 1'b0;
    sram_addr   = '0;
    sram_wmask  = '0;
    sram_wdata  = '0;

    case (r_state)
      ST_INIT: begin
        // Macro outputs are gated by the reset input so nothing is written
        // while reset is held.
        if (!reset) begin
          sram_en    = 1'b1;
          sram_wmode = 1'b1;
          sram_wmask = '1;
          sram_addr  = r_fill;
        end
        if (r_fill == {ADDR_W{1'b1}}) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!reset) begin
          if (&w_elig) begin
            w_gnt = r_last_req1 ? 2'b01 : 2'b10;
          end else begin
            w_gnt = w_elig;
          end
        end
        if (w_gnt[0]) begin
          // A write with no lanes enabled is accepted but never reaches the macro.
          sram_en    = req0_write ? (|req0_mask) : 1'b1;
          sram_wmode = req0_write;
          sram_addr  = req0_addr;
          sram_wmask = req0_write ? req0_mask  : '0;
          sram_wdata = req0_write ? req0_wdata : '0;
        end else if (w_gnt[1]) begin
          sram_en    = req1_write ? (|req1_mask) : 1'b1;
          sram_wmode = req1_write;
          sram_addr  = req1_addr;
          sram_wmask = req1_write ? req1_mask  : '0;
          sram_wdata = req1_write ? req1_wdata : '0;
        end
      end
      default: begin
        w_state_nxt = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      if (CLEAR_ON_RESET) begin
        r_state <= ST_INIT;
      end else begin
        r_state <= ST_RUN;
      end
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_fill        <= '0;
      r_last_req1   <= 1'b1;
      r_rd_infl     <= 2'b00;
      r_resp_valid  <= 2'b00;
      r_resp_rdata0 <= '0;
      r_resp_rdata1 <= '0;
    end else begin
      if (r_state == ST_INIT) begin
        r_fill <= r_fill + 1'b1;
      end
      if (|w_gnt) begin
        r_last_req1 <= w_gnt[1];
      end
      r_rd_infl <= w_gnt & ~w_write;

      // Macro read data is only valid in the cycle after the access.
      if (r_rd_infl[0]) begin
        r_resp_valid[0] <= 1'b1;
        r_resp_rdata0   <= sram_rdata;
      end else if (r_resp_valid[0] && resp0_ready) begin
        r_resp_valid[0] <= 1'b0;
      end
      if (r_rd_infl[1]) begin
        r_resp_valid[1] <= 1'b1;
        r_resp_rdata1   <= sram_rdata;
      end else if (r_resp_valid[1] && resp1_ready) begin
        r_resp_valid[1] <= 1'b0;
      end
    end
  end

  assign init_done   = (r_state == ST_RUN);
  assign req0_ready  = w_gnt[0];
  assign req1_ready  = w_gnt[1];
  assign resp0_valid = r_resp_valid[0];
  assign resp1_valid = r_resp_valid[1];
  assign resp0_rdata = r_resp_rdata0;
  assign resp1_rdata = r_resp_rdata1;

endmodule
`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sram_port_arbiter
//  Purpose  : Self-checking bench for sram_port_arbiter. A behavioural SRAM
//             macro sits on the memory side; a scoreboard of expected read
//             responses plus a reference memory and a round-robin model are
//             compared against the DUT every cycle by a monitor process.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sram_port_arbiter;

  localparam int AW = 12;
  localparam int DW = 64;
  localparam int MW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]    v  = '0;
  logic [1:0]    w  = '0;
  logic [1:0]    rr = '0;
  logic [AW-1:0] a [2];
  logic [MW-1:0] m [2];
  logic [DW-1:0] d [2];

  wire           init_done;
  wire           req0_ready, req1_ready, resp0_valid, resp1_valid;
  wire [DW-1:0]  resp0_rdata, resp1_rdata;
  wire           sram_en, sram_wmode;
  wire [AW-1:0]  sram_addr;
  wire [MW-1:0]  sram_wmask;
  wire [DW-1:0]  sram_wdata;
  logic [DW-1:0] sram_rdata = '0;

  sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MASK_W(MW), .CLEAR_ON_RESET(1'b1)) dut (
    .clock(clk), .reset(rst), .init_done(init_done),
    .req0_valid(v[0]), .req0_ready(req0_ready), .req0_write(w[0]), .req0_addr(a[0]),
    .req0_mask(m[0]), .req0_wdata(d[0]),
    .req1_valid(v[1]), .req1_ready(req1_ready), .req1_write(w[1]), .req1_addr(a[1]),
    .req1_mask(m[1]), .req1_wdata(d[1]),
    .resp0_valid(resp0_valid), .resp0_ready(rr[0]), .resp0_rdata(resp0_rdata),
    .resp1_valid(resp1_valid), .resp1_ready(rr[1]), .resp1_rdata(resp1_rdata),
    .sram_en(sram_en), .sram_wmode(sram_wmode), .sram_addr(sram_addr),
    .sram_wmask(sram_wmask), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  wire [1:0]     rdy = {req1_ready, req0_ready};
  wire [1:0]     rv  = {resp1_valid, resp0_valid};
  logic [DW-1:0] rdat [2];
  always_comb begin
    rdat[0] = resp0_rdata;
    rdat[1] = resp1_rdata;
  end

  // Behavioural macro: lane-masked write, 1-cycle read, garbage otherwise.
  logic [DW-1:0] mem [1<<AW];
  always @(posedge clk) begin
    logic [DW-1:0] t;
    if (sram_en && sram_wmode) begin
      t = mem[sram_addr];
      for (int l = 0; l < MW; l++) if (sram_wmask[l]) t[l*16 +: 16] = sram_wdata[l*16 +: 16];
      mem[sram_addr] <= t;
    end
    if (sram_en && !sram_wmode) sram_rdata <= mem[sram_addr];
    else                        sram_rdata <= {$urandom, $urandom};
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timed out, got no event, expected one (cycle %0d)", nm, cyc);
  endtask

  // ---------------------------------------------------------------- model
  typedef struct {
    int            who;
    int            due;
    logic [DW-1:0] data;
  } rsp_t;

  rsp_t          sb[$];
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  bit            m_last = 1'b1;
  bit            run_mode = 1'b0;

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] ad);
    return ref_mem.exists(ad) ? ref_mem[ad] : '0;
  endfunction

  int            idx [2];
  bit            occ [2];
  bit            infl[2];
  bit            el  [2];
  int            g;
  bit            exp_en;
  logic [DW-1:0] tword;
  rsp_t          keep[$];

  always @(negedge clk) begin
    if (!run_mode) begin
      sb.delete();
      ref_mem.delete();
      m_last = 1'b1;
    end else begin
      for (int i = 0; i < 2; i++) begin
        idx[i] = -1;
        foreach (sb[k]) if (sb[k].who == i && idx[i] < 0) idx[i] = k;
        occ[i]  = (idx[i] >= 0) && (sb[idx[i]].due <= cyc);
        infl[i] = (idx[i] >= 0) && (sb[idx[i]].due == cyc + 1);
        chk($sformatf("resp%0d_valid", i), {63'b0, rv[i]}, {63'b0, occ[i]});
        if (occ[i]) chk($sformatf("resp%0d_rdata", i), rdat[i], sb[idx[i]].data);
        el[i] = v[i] && (w[i] || (!infl[i] && (!occ[i] || rr[i])));
      end
      if (el[0] && el[1]) g = m_last ? 0 : 1;
      else if (el[0])     g = 0;
      else if (el[1])     g = 1;
      else                g = -1;
      chk("req0_ready", {63'b0, rdy[0]}, {63'b0, (g == 0)});
      chk("req1_ready", {63'b0, rdy[1]}, {63'b0, (g == 1)});
      exp_en = (g >= 0) ? (!w[g] || (m[g] != '0)) : 1'b0;
      chk("sram_en", {63'b0, sram_en}, {63'b0, exp_en});
      if (exp_en) begin
        chk("sram_addr",  {52'b0, sram_addr}, {52'b0, a[g]});
        chk("sram_wmode", {63'b0, sram_wmode}, {63'b0, w[g]});
        if (w[g]) begin
          chk("sram_wmask", {60'b0, sram_wmask}, {60'b0, m[g]});
          chk("sram_wdata", sram_wdata, d[g]);
        end
      end
      keep.delete();
      foreach (sb[k]) if (!(sb[k].due <= cyc && rr[sb[k].who])) keep.push_back(sb[k]);
      sb = keep;
      if (g >= 0) begin
        m_last = (g == 1);
        if (w[g]) begin
          tword = ref_rd(a[g]);
          for (int l = 0; l < MW; l++) if (m[g][l]) tword[l*16 +: 16] = d[g][l*16 +: 16];
          ref_mem[a[g]] = tword;
        end else begin
          sb.push_back('{g, cyc + 2, ref_rd(a[g])});
        end
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input int i, input bit wr, input logic [AW-1:0] ad,
                        input logic [MW-1:0] mk, input logic [DW-1:0] dt, output int acc);
    bit got;
    got = 1'b0;
    acc = -1;
    w[i] = wr; a[i] = ad; m[i] = mk; d[i] = dt; v[i] = 1'b1;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if (rdy[i]) begin
        got = 1'b1;
        acc = cyc;
      end
      tick();
    end
    v[i] = 1'b0;
    if (!got) timeout_fail($sformatf("req%0d_accept", i));
  endtask

  task automatic wait_resp(input int i, output logic [DW-1:0] dat, output int rc);
    bit got;
    got = 1'b0;
    dat = '0;
    rc  = -1;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (rv[i]) begin
        got = 1'b1;
        dat = rdat[i];
        rc  = cyc;
      end
    end
    if (!got) timeout_fail($sformatf("resp%0d_wait", i));
  endtask

  task automatic init_check();
    for (int k = 0; k < (1 << AW); k++) begin
      @(negedge clk);
      chk("init_step",
          {40'b0, init_done, rdy, rv, sram_en, sram_wmode, sram_wmask, (sram_wdata != '0), sram_addr},
          {40'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 4'hF, 1'b0, AW'(k)});
      tick();
    end
    @(negedge clk);
    chk("init_done_rise", {63'b0, init_done}, 64'd1);
    tick();
    run_mode = 1'b1;
  endtask

  logic [DW-1:0] dat;
  int            c, rc, cnt0, cnt1;
  bit            got;
  logic [1:0]    acc;

  initial begin
    a[0] = '0; a[1] = '0; m[0] = '0; m[1] = '0; d[0] = '0; d[1] = '0;

    // reset release and zero-fill, then read back a cleared word
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    init_check();
    rr = 2'b11;
    do_req(1, 1'b0, 12'h7FF, 4'h0, '0, c);
    wait_resp(1, dat, rc);
    chk("read_7ff_zero", dat, 64'h0);
    chk("read_7ff_latency", 64'(rc - c), 64'd2);

    // full write then partial lane write, read-after-write
    do_req(0, 1'b1, 12'h010, 4'hF, 64'h1111_2222_3333_4444, c);
    do_req(0, 1'b1, 12'h010, 4'h5, 64'hAAAA_BBBB_CCCC_DDDD, c);
    do_req(0, 1'b0, 12'h010, 4'h0, '0, c);
    wait_resp(0, dat, rc);
    chk("lane_merge", dat, 64'h1111_BBBB_3333_DDDD);
    chk("lane_merge_latency", 64'(rc - c), 64'd2);

    // both requesters hold writes: grants alternate
    v = 2'b11; w = 2'b11;
    a[0] = 12'h040; a[1] = 12'h041; m[0] = 4'hF; m[1] = 4'hF;
    d[0] = {$urandom, $urandom}; d[1] = {$urandom, $urandom};
    cnt0 = 0; cnt1 = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      cnt0 += int'(rdy[0]);
      cnt1 += int'(rdy[1]);
      tick();
    end
    v = 2'b00;
    chk("alt_count0", 64'(cnt0), 64'd3);
    chk("alt_count1", 64'(cnt1), 64'd3);

    // response back-pressure on req1 while req0 streams writes
    rr = 2'b01;
    do_req(1, 1'b0, 12'h010, 4'h0, '0, c);
    v = 2'b11; w = 2'b01;
    a[1] = 12'h041; a[0] = 12'h050; m[0] = 4'hF; d[0] = {$urandom, $urandom};
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("hold_req0_granted", {63'b0, rdy[0]}, 64'd1);
      chk("hold_req1_blocked", {63'b0, rdy[1]}, 64'd0);
      if (rv[1]) chk("hold_resp1_stable", rdat[1], 64'h1111_BBBB_3333_DDDD);
      tick();
      a[0] = a[0] + 1'b1;
      d[0] = {$urandom, $urandom};
    end
    v[0] = 1'b0;
    rr[1] = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (rdy[1]) got = 1'b1;
      tick();
    end
    v[1] = 1'b0;
    if (!got) timeout_fail("req1_second_read");
    repeat (4) tick();

    // mask-0 write is accepted but leaves memory untouched
    do_req(0, 1'b1, 12'h030, 4'hF, 64'h0123_4567_89AB_CDEF, c);
    v[0] = 1'b1; w[0] = 1'b1; a[0] = 12'h030; m[0] = 4'h0; d[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    chk("mask0_ready", {63'b0, rdy[0]}, 64'd1);
    chk("mask0_sram_en", {63'b0, sram_en}, 64'd0);
    tick();
    v[0] = 1'b0;
    do_req(0, 1'b0, 12'h030, 4'h0, '0, c);
    wait_resp(0, dat, rc);
    chk("mask0_readback", dat, 64'h0123_4567_89AB_CDEF);
    repeat (2) tick();

    // reset with a buffered response and a read in flight
    rr = 2'b00;
    do_req(0, 1'b0, 12'h010, 4'h0, '0, c);
    wait_resp(0, dat, rc);
    tick();
    rr[1] = 1'b1;
    do_req(1, 1'b0, 12'h011, 4'h0, '0, c);
    #2;
    run_mode = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_resp0_valid", {63'b0, resp0_valid}, 64'd0);
    chk("rst_resp1_valid", {63'b0, resp1_valid}, 64'd0);
    chk("rst_sram_en", {63'b0, sram_en}, 64'd0);
    v = 2'b00;
    rr = 2'b11;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    init_check();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("no_resp_after_reset", {62'b0, rv}, 64'd0);
      tick();
    end

    // randomized traffic on a small address window
    acc = 2'b00;
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (!v[i] || acc[i]) begin
          v[i] = ($urandom % 4) != 0;
          w[i] = $urandom % 2;
          a[i] = 12'h100 + 12'($urandom % 16);
          m[i] = (($urandom % 8) == 0) ? 4'h0 : 4'($urandom);
          d[i] = {$urandom, $urandom};
        end
        rr[i] = ($urandom % 3) != 0;
      end
      @(negedge clk);
      acc = rdy;
      tick();
    end
    v = 2'b00;
    rr = 2'b11;
    repeat (10) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
